// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and default constants for the memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, D_ACC, I_ACC, RESP)
//   grant_t     : which pipeline port owns the current access
//   *_DEF       : default parameter values used by mem_port_arbiter
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_LIM_DEF = 4;
    localparam int MAX_WAIT_DEF   = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Request/response bus between the arbiter and the single-port memory.
//   mem_req   : request, held until mem_ready
//   mem_we    : 1 = write
//   mem_addr  : access address
//   mem_wdata : write data
//   mem_be    : byte enables (DATA_W/8 bits)
//   mem_ready : memory completes the access this cycle
//   mem_rdata : read data, valid with mem_ready
// Modports: master = arbiter side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
    import arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ready;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// -----------------------------------------------------------------------------
// arb_wait_timer
// Counts cycles an access has waited for mem_ready.
//   clk, rst : clock, synchronous active-high reset
//   load     : clear the count (access is being granted)
//   inc      : one more cycle without mem_ready
//   expire   : this waiting cycle is the MAX_WAIT-th one; abort the access
// -----------------------------------------------------------------------------
module arb_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic expire
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    // Firing on MAX_WAIT-1 makes the request visible for exactly MAX_WAIT cycles.
    assign expire = inc && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, variable-latency memory between the fetch port (I,
// read-only) and the data port (D, load/store). D has priority; after
// STARVE_LIM consecutive D grants with a fetch waiting, I is forced.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_req/i_addr    fetch request, held until i_valid
//   i_rdata/i_valid fetch data and one-cycle completion pulse
//   i_stall         i_req & ~i_valid
//   d_req/d_we/d_addr/d_wdata/d_be  data request, held until d_valid
//   d_rdata/d_valid load data (0 for stores) and completion pulse
//   d_stall         d_req & ~d_valid
//   mem             memory bus (mem_port_arbiter_if.master)
//   bus_err         pulses with valid on a timeout abort
//   busy            FSM not in IDLE
//
// Optional macro ARB_TIMEOUT_EN: aborts an access after MAX_WAIT cycles
// without mem_ready; completion then reports bus_err = 1 and rdata = 0.
// Without it the arbiter waits indefinitely and bus_err is tied 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_valid,
    output logic                i_stall,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                d_stall,

    mem_port_arbiter_if.master  mem,

    output logic                bus_err,
    output logic                busy
);

    localparam logic [3:0] LIM = STARVE_LIM[3:0];

    arb_state_t            state_q,     state_d;
    grant_t                gnt_q,       gnt_d;
    logic [3:0]            streak_q,    streak_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0]   mem_be_q,    mem_be_d;
    logic [DATA_W-1:0]     i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q,   d_rdata_d;

    logic                  in_access;
    logic                  i_forced;

    assign in_access = (state_q == D_ACC) || (state_q == I_ACC);
    // Fetch has waited through STARVE_LIM data grants; it wins this arbitration.
    assign i_forced  = i_req && (streak_q == LIM);

`ifdef ARB_TIMEOUT_EN
    logic bus_err_q, bus_err_d;
    logic timer_load, timer_inc, timer_expire;

    assign timer_load = (state_q == IDLE);
    assign timer_inc  = in_access && !mem.mem_ready;

    arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .inc    (timer_inc),
        .expire (timer_expire)
    );
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        streak_d    = streak_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
        bus_err_d   = bus_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (d_req && !i_forced) begin
                    state_d     = D_ACC;
                    gnt_d       = GNT_D;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    // Only grants that overtake a waiting fetch count toward starvation.
                    if (i_req) begin
                        streak_d = (streak_q == LIM) ? LIM : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end else if (i_req) begin
                    state_d     = I_ACC;
                    gnt_d       = GNT_I;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    streak_d    = 4'd0;
                end
            end

            D_ACC, I_ACC: begin
                if (mem.mem_ready) begin
                    state_d = RESP;
                    if (gnt_q == GNT_D) begin
                        d_rdata_d = mem_we_q ? '0 : mem.mem_rdata;
                    end else begin
                        i_rdata_d = mem.mem_rdata;
                    end
`ifdef ARB_TIMEOUT_EN
                    bus_err_d = 1'b0;
                end else if (timer_expire) begin
                    state_d   = RESP;
                    bus_err_d = 1'b1;
                    if (gnt_q == GNT_D) begin
                        d_rdata_d = '0;
                    end else begin
                        i_rdata_d = '0;
                    end
`endif
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_I;
            streak_q    <= 4'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            streak_q    <= streak_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q && (state_q == RESP);
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_WAIT == 0);
    assign bus_err    = 1'b0;
`endif

    assign mem.mem_req   = in_access;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;

    assign i_valid = (state_q == RESP) && (gnt_q == GNT_I);
    assign d_valid = (state_q == RESP) && (gnt_q == GNT_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_stall = i_req && !i_valid;
    assign d_stall = d_req && !d_valid;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. A small memory responder raises
// mem_ready `lat` cycles after mem_req first appears (when mem_en is set).
// The timeout scenario is compiled in only with ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_valid;
    logic          i_stall;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [3:0]    d_be = 4'h0;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_stall;
    logic          bus_err;
    logic          busy;

    logic          mem_en = 1'b1;
    int            lat = 1;
    int            wait_cnt = 0;
    logic [DW-1:0] rd_val = '0;

    int n_pass = 0;
    int n_total = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_LIM (4),
        .MAX_WAIT   (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_valid (i_valid),
        .i_stall (i_stall),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_be    (d_be),
        .d_rdata (d_rdata),
        .d_valid (d_valid),
        .d_stall (d_stall),
        .mem     (mem_if),
        .bus_err (bus_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Memory model: updates on the falling edge so the arbiter sees stable inputs.
    always @(negedge clk) begin
        mem_if.mem_rdata = rd_val;
        if (mem_en && mem_if.mem_req === 1'b1) begin
            if (wait_cnt == lat) begin
                mem_if.mem_ready = 1'b1;
                wait_cnt = 0;
            end else begin
                mem_if.mem_ready = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            mem_if.mem_ready = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b, expected %b", tag, obs, exp);
    endtask

    // Steps until the selected valid is seen (bounded); returns cycles stepped.
    task automatic wait_valid(input bit is_d, input string tag, output int cyc);
        cyc = 0;
        while (cyc < 60 && !(is_d ? d_valid : i_valid)) begin
            step();
            cyc++;
        end
        check1(tag, is_d ? d_valid : i_valid, 1'b1);
    endtask

    logic [AW-1:0] grants [6];
    logic [AW-1:0] exp_gnt [6];
    int            ngnt;
    logic          prev_req;
    int            cyc;
    int            reqcyc;

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        step(); step();
        check1("rst mem_req", mem_if.mem_req, 1'b0);
        check1("rst busy", busy, 1'b0);
        check1("rst i_valid", i_valid, 1'b0);
        check1("rst d_valid", d_valid, 1'b0);
        check1("rst bus_err", bus_err, 1'b0);
        check("rst mem_addr", mem_if.mem_addr, 32'h0);
        check("rst i_rdata", i_rdata, 32'h0);
        check("rst d_rdata", d_rdata, 32'h0);
        rst = 1'b0;
        step();

        // ---------------- single fetch ----------------
        lat = 1; rd_val = 32'h0050_0093;
        i_req = 1'b1; i_addr = 32'h0000_0010;             // cycle 0
        step();                                            // cycle 1
        check1("t1 mem_req c1", mem_if.mem_req, 1'b1);
        check("t1 mem_addr", mem_if.mem_addr, 32'h10);
        check1("t1 mem_we", mem_if.mem_we, 1'b0);
        check("t1 mem_be", 32'(mem_if.mem_be), 32'hF);
        check1("t1 i_stall c1", i_stall, 1'b1);
        step();                                            // cycle 2
        check1("t1 i_valid c2", i_valid, 1'b0);
        step();                                            // cycle 3
        check1("t1 i_valid c3", i_valid, 1'b1);
        check("t1 i_rdata", i_rdata, 32'h0050_0093);
        check1("t1 i_stall c3", i_stall, 1'b0);
        check1("t1 d_valid", d_valid, 1'b0);
        $display("txn fetch addr=0x%08h rdata=0x%08h", i_addr, i_rdata);
        i_req = 1'b0;
        step();
        check1("t1 i_valid c4", i_valid, 1'b0);
        check1("t1 busy c4", busy, 1'b0);

        // ---------------- simultaneous I and D ----------------
        rd_val = 32'h1111_2222;
        i_req = 1'b1; i_addr = 32'h0000_0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100; d_be = 4'hF;  // cycle 0
        step();                                            // cycle 1
        check("t2 D first addr", mem_if.mem_addr, 32'h100);
        check1("t2 i_stall", i_stall, 1'b1);
        step();                                            // cycle 2
        wait_valid(1'b1, "t2 d_valid", cyc);               // cycle 3
        check("t2 d_valid cycle", cyc, 32'd1);
        check("t2 d_rdata", d_rdata, 32'h1111_2222);
        check1("t2 no i_valid", i_valid, 1'b0);
        $display("txn load addr=0x%08h rdata=0x%08h", d_addr, d_rdata);
        d_req = 1'b0;
        rd_val = 32'h3333_4444;
        step();                                            // cycle 4 (IDLE bubble)
        check1("t2 bubble", mem_if.mem_req, 1'b0);
        step();                                            // cycle 5
        check1("t2 I mem_req", mem_if.mem_req, 1'b1);
        check("t2 I addr", mem_if.mem_addr, 32'h10);
        wait_valid(1'b0, "t2 i_valid", cyc);               // cycle 7
        check("t2 I after D gap", cyc, 32'd2);
        check("t2 i_rdata", i_rdata, 32'h3333_4444);
        check("t2 d_rdata held", d_rdata, 32'h1111_2222);
        $display("txn fetch addr=0x%08h rdata=0x%08h", i_addr, i_rdata);
        i_req = 1'b0;
        step();

        // ---------------- starvation limit ----------------
        rd_val = 32'hA5A5_5A5A;
        i_req = 1'b1; i_addr = 32'h0000_0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
        ngnt = 0; prev_req = 1'b0;
        for (int k = 0; k < 200 && ngnt < 6; k++) begin
            step();
            if (mem_if.mem_req && !prev_req) begin
                grants[ngnt] = mem_if.mem_addr;
                $display("txn grant %0d addr=0x%08h", ngnt, mem_if.mem_addr);
                ngnt++;
            end
            prev_req = mem_if.mem_req;
        end
        check("t3 grant count", ngnt, 32'd6);
        exp_gnt[0] = 32'h200; exp_gnt[1] = 32'h200; exp_gnt[2] = 32'h200;
        exp_gnt[3] = 32'h200; exp_gnt[4] = 32'h40;  exp_gnt[5] = 32'h200;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t3 grant%0d", k), grants[k], exp_gnt[k]);
        end
        i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 20 && busy; k++) step();
        check1("t3 drained", busy, 1'b0);
        step();

        // ---------------- delayed store ----------------
        lat = 5; rd_val = 32'h1234_5678;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0300;
        d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;           // cycle 0
        for (int c = 1; c <= 6; c++) begin
            step();
            check1($sformatf("t4 mem_req c%0d", c), mem_if.mem_req, 1'b1);
            check1($sformatf("t4 mem_we c%0d", c), mem_if.mem_we, 1'b1);
            check($sformatf("t4 mem_addr c%0d", c), mem_if.mem_addr, 32'h300);
            check($sformatf("t4 mem_wdata c%0d", c), mem_if.mem_wdata, 32'hDEAD_BEEF);
            check($sformatf("t4 mem_be c%0d", c), 32'(mem_if.mem_be), 32'h3);
            check1($sformatf("t4 d_stall c%0d", c), d_stall, 1'b1);
            check1($sformatf("t4 d_valid c%0d", c), d_valid, 1'b0);
        end
        step();                                            // cycle 7
        check1("t4 d_valid", d_valid, 1'b1);
        check("t4 d_rdata", d_rdata, 32'h0);
        check1("t4 d_stall", d_stall, 1'b0);
        check1("t4 bus_err", bus_err, 1'b0);
        $display("txn store addr=0x%08h wdata=0x%08h be=%b", d_addr, d_wdata, d_be);
        d_req = 1'b0; d_we = 1'b0;
        step();
        check1("t4 d_valid single", d_valid, 1'b0);

        // ---------------- reset mid-access ----------------
        lat = 1; mem_en = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_0080;              // cycle 0
        step();                                            // cycle 1
        check1("t5 mem_req c1", mem_if.mem_req, 1'b1);
        step();                                            // cycle 2
        check1("t5 mem_req c2", mem_if.mem_req, 1'b1);
        rst = 1'b1;
        step();                                            // cycle 3
        check1("t5 mem_req after rst", mem_if.mem_req, 1'b0);
        check1("t5 busy after rst", busy, 1'b0);
        check1("t5 i_valid after rst", i_valid, 1'b0);
        check("t5 i_rdata cleared", i_rdata, 32'h0);
        rst = 1'b0; i_req = 1'b0; mem_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check1($sformatf("t5 no i_valid %0d", k), i_valid, 1'b0);
        end
        rd_val = 32'hCAFE_F00D;
        i_req = 1'b1; i_addr = 32'h0000_00C0;
        wait_valid(1'b0, "t5 refetch valid", cyc);
        check("t5 refetch latency", cyc, 32'd3);
        check("t5 refetch rdata", i_rdata, 32'hCAFE_F00D);
        $display("txn fetch addr=0x%08h rdata=0x%08h", i_addr, i_rdata);
        i_req = 1'b0;
        step();

`ifdef ARB_TIMEOUT_EN
        // ---------------- timeout abort ----------------
        mem_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400; d_be = 4'hF;
        reqcyc = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!mem_if.mem_req) break;
            reqcyc++;
        end
        check("t6 mem_req cycles", reqcyc, 32'd15);
        check1("t6 d_valid", d_valid, 1'b1);
        check1("t6 bus_err", bus_err, 1'b1);
        check("t6 d_rdata", d_rdata, 32'h0);
        $display("txn timeout addr=0x%08h bus_err=%b", d_addr, bus_err);
        d_req = 1'b0; mem_en = 1'b1;
        step();
        check1("t6 bus_err single", bus_err, 1'b0);
`else
        reqcyc = 0;
        check1("no-timeout bus_err", bus_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
